// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN to replace the multiply iterations with one combinational multiplier.
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] rd_data_o,
    output logic [4:0]      rd_addr_o,
    output logic            reg_wen_o,
    output logic            hold_flag_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t state, state_d;

    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   mag_a, mag_b, quo, res;
    logic [XLEN:0]     rem;
    logic [2*XLEN-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              neg_q;

    logic              s1, s2, a_neg, b_neg, sign_in;
    logic              div_zero, ovf, special, start_ok, mul_fast;
    logic [XLEN-1:0]   mag1, mag2, spec_res;
    logic [2*XLEN-1:0] acc_init;

    // Operand decode at start: magnitudes, result sign, and the no-iteration cases.
    always_comb begin
        s1 = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
             (funct3_i == 3'b100) || (funct3_i == 3'b110);
        s2 = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
        a_neg = s1 && op1_i[XLEN-1];
        b_neg = s2 && op2_i[XLEN-1];
        mag1  = a_neg ? -op1_i : op1_i;
        mag2  = b_neg ? -op2_i : op2_i;
        sign_in = 1'b0;
        case (funct3_i)
            3'b001, 3'b100: sign_in = a_neg ^ b_neg;
            3'b010, 3'b110: sign_in = a_neg;
            default:        sign_in = 1'b0;
        endcase
        div_zero = funct3_i[2] && (op2_i == '0);
        ovf      = funct3_i[2] && !funct3_i[0] && (op1_i == MIN_NEG) && (&op2_i);
        special  = div_zero || ovf;
        if (div_zero)
            spec_res = funct3_i[1] ? op1_i : '1;
        else
            spec_res = funct3_i[1] ? '0 : op1_i;
    end

`ifdef MULDIV_FAST_MUL_EN
    assign mul_fast = !funct3_i[2];
    assign acc_init = funct3_i[2] ? {{XLEN{1'b0}}, mag2}
                                  : {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
`else
    assign mul_fast = 1'b0;
    assign acc_init = {{XLEN{1'b0}}, mag2};
`endif

    assign start_ok    = start_i && (state == IDLE) && !flush_i;
    assign hold_flag_o = start_ok || (!flush_i && ((state == CALC) || (state == FIX)));
    assign reg_wen_o   = (state == DONE) && !flush_i;
    assign busy_o      = (state != IDLE);
    assign rd_data_o   = reg_wen_o ? res : '0;
    assign rd_addr_o   = reg_wen_o ? rd_q : '0;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    if (special)
                        state_d = DONE;
                    else if (mul_fast)
                        state_d = FIX;
                    else
                        state_d = CALC;
                end
            end
            CALC:    if (cnt == CNT_W'(1)) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i)
            state_d = IDLE;
    end

    // One iteration step: multiplicand added into the upper half, then shift right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN+1:0]   div_wide, div_diff;
    logic              div_ge;
    logic [XLEN:0]     rem_next;
    logic [XLEN-1:0]   quo_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
        div_wide = {rem, quo[XLEN-1]};
        div_diff = div_wide - {2'b00, mag_b};
        div_ge   = !div_diff[XLEN+1];
        rem_next = div_ge ? div_diff[XLEN:0] : div_wide[XLEN:0];
        quo_next = {quo[XLEN-2:0], div_ge};
    end

    logic [2*XLEN-1:0] prod_sgn;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod_sgn = neg_q ? -acc : acc;
        fix_res  = '0;
        if (!f3_q[2])
            fix_res = (f3_q[1:0] == 2'b00) ? prod_sgn[XLEN-1:0] : prod_sgn[2*XLEN-1:XLEN];
        else if (f3_q[1])
            fix_res = neg_q ? -rem[XLEN-1:0] : rem[XLEN-1:0];
        else
            fix_res = neg_q ? -quo : quo;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f3_q  <= '0;
            rd_q  <= '0;
            mag_a <= '0;
            mag_b <= '0;
            quo   <= '0;
            rem   <= '0;
            acc   <= '0;
            res   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        f3_q  <= funct3_i;
                        rd_q  <= rd_addr_i;
                        mag_a <= mag1;
                        mag_b <= mag2;
                        neg_q <= sign_in;
                        cnt   <= CNT_W'(XLEN);
                        rem   <= '0;
                        quo   <= mag1;
                        acc   <= acc_init;
                        if (special)
                            res <= spec_res;
                    end
                end
                CALC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (f3_q[2]) begin
                        rem <= rem_next;
                        quo <= quo_next;
                    end else begin
                        acc <= mul_next;
                    end
                end
                FIX:     res <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed RV32M vectors, flush, reset and held-start cases.
module tb_ex_muldiv;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MLAT = 2;
`else
    localparam int MLAT = 34;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] op1_i, op2_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic [31:0] rd_data_o;
    logic [4:0]  rd_addr_o;
    logic        reg_wen_o, hold_flag_o, busy_o;

    ex_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .funct3_i(funct3_i),
        .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
        .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o), .reg_wen_o(reg_wen_o),
        .hold_flag_o(hold_flag_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    logic [31:0] cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] cyc;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[15];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expectation, cycle included.
    always @(negedge clk) begin
        if (reg_wen_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got data %h rd %0d at cycle %0d, expected no write",
                         rd_data_o, rd_addr_o, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_data", rd_data_o, e.data);
                chk("wr_addr", {27'd0, rd_addr_o}, {27'd0, e.rd});
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic push_exp(input logic [31:0] d, input logic [4:0] rd, input logic [31:0] c);
        exp_t e;
        e.data = d;
        e.rd   = rd;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic op(input int id, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] r, input int lat);
        int bad;
        logic [31:0] t0;
        @(posedge clk); #1;
        funct3_i = f3; op1_i = a; op2_i = b; rd_addr_i = rd; start_i = 1'b1;
        t0 = cyc;
        push_exp(r, rd, t0 + lat);
        bad = 0;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            if (hold_flag_o !== 1'b1) bad++;
            @(posedge clk); #1;
            start_i = 1'b0;
            op1_i = $urandom;
            op2_i = $urandom;
        end
        @(negedge clk);
        chk($sformatf("hold_window_bad_cycles op%0d", id), bad, 0);
        chk($sformatf("hold_in_done op%0d", id), {31'd0, hold_flag_o}, 0);
        @(posedge clk); #1;
        chk($sformatf("idle_after op%0d", id), {31'd0, busy_o}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t0;
        vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MLAT};
        vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MLAT};
        vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MLAT};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MLAT};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
        vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       34};
        vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        34};
        vecs[8]  = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,        1};
        vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
        vecs[12] = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[13] = '{3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, MLAT};
        vecs[14] = '{3'b100, 32'd1000,     32'hFFFFFFF6, 32'hFFFFFF9C, 34};

        rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
        funct3_i = 3'b000; op1_i = '0; op2_i = '0; rd_addr_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_data", rd_data_o, 0);
        chk("rst_rd_addr", {27'd0, rd_addr_o}, 0);
        chk("rst_reg_wen", {31'd0, reg_wen_o}, 0);
        chk("rst_busy", {31'd0, busy_o}, 0);
        chk("rst_hold", {31'd0, hold_flag_o}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++)
            op(i, vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].r, vecs[i].lat);

        // Destination x0 still produces a write strobe.
        op(20, 3'b000, 32'd3, 32'd4, 5'd0, 32'd12, MLAT);

        // Flush mid-divide, then a fresh start two cycles later.
        @(posedge clk); #1;
        funct3_i = 3'b101; op1_i = 32'd100; op2_i = 32'd7; rd_addr_i = 5'd9; start_i = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_hold", {31'd0, hold_flag_o}, 0);
        chk("flush_wen", {31'd0, reg_wen_o}, 0);
        chk("flush_cycle", cyc, t0 + 10);
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush_idle", {31'd0, busy_o}, 0);
        op(21, 3'b111, 32'd100, 32'd7, 5'd10, 32'd2, 34);

        // Reset in the middle of a multiply.
        @(posedge clk); #1;
        funct3_i = 3'b000; op1_i = 32'd7; op2_i = 32'd9; rd_addr_i = 5'd11; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_rd_data", rd_data_o, 0);
        chk("midrst_rd_addr", {27'd0, rd_addr_o}, 0);
        chk("midrst_reg_wen", {31'd0, reg_wen_o}, 0);
        chk("midrst_busy", {31'd0, busy_o}, 0);
        chk("midrst_hold", {31'd0, hold_flag_o}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);

        // start_i held through DONE: ignored there, re-accepted once back in IDLE.
        @(posedge clk); #1;
        funct3_i = 3'b101; op1_i = 32'd100; op2_i = 32'd7; rd_addr_i = 5'd12; start_i = 1'b1;
        t0 = cyc;
        push_exp(32'd14, 5'd12, t0 + 34);
        push_exp(32'd14, 5'd12, t0 + 69);
        repeat (36) @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("held_start_idle", {31'd0, busy_o}, 0);

        repeat (5) @(posedge clk);
        chk("pending_expectations", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
